vga_tile_fetch: RTL

//  Display-side reader of the packed text screen buffer (600 words x 28 bit, 4 chars of 7 bit each).

---
 rtl/vga_tile_fetch_pkg.sv | 36 +++
 rtl/vga_delay_line.sv | 32 +++
 rtl/vga_tile_fetch.sv | 132 +++++++++++++
 3 files changed

// File: rtl/vga_tile_fetch_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : vga_tile_fetch_pkg                                           |
// | Description : Shared text-mode geometry constants and the delayed-control |
// |               bundle for the display-side tile fetch pipeline.             |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package vga_tile_fetch_pkg;

  localparam int c_h_tiles       = 80;
  localparam int c_v_tiles       = 30;
  localparam int c_num_addrs     = 600;
  localparam int c_words_per_row = 20;
  localparam int c_char_w        = 7;
  localparam int c_word_chars    = 4;
  localparam int c_addr_width    = 10;
  localparam int c_tile_w        = 8;
  localparam int c_tile_h        = 16;
  localparam int c_h_active      = 640;
  localparam int c_v_active      = 480;

  // Everything that rides alongside the buffer read unchanged.
  typedef struct packed {
    logic       hsync;
    logic       vsync;
    logic       video_on;
    logic [3:0] glyph_row;
    logic [2:0] glyph_col;
  } ctrl_t;

  // Syncs are negative polarity, so their idle level is 1.
  localparam ctrl_t c_ctrl_reset = '{hsync: 1'b1, vsync: 1'b1, video_on: 1'b0,
                                     glyph_row: 4'd0, glyph_col: 3'd0};

endpackage
`default_nettype wire

// File: rtl/vga_delay_line.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : vga_delay_line                                               |
// | Description : Resettable DEPTH-stage shift register of WIDTH bits.         |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module vga_delay_line #(
  parameter int               WIDTH     = 1,
  parameter int               DEPTH     = 3,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] r_stage [DEPTH];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < DEPTH; i++) r_stage[i] <= RESET_VAL;
    end else begin
      r_stage[0] <= d_i;
      for (int i = 1; i < DEPTH; i++) r_stage[i] <= r_stage[i-1];
    end
  end

  assign q_o = r_stage[DEPTH-1];

endmodule
`default_nettype wire

// File: rtl/vga_tile_fetch.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : vga_tile_fetch                                               |
// | Description : Turns the pixel position into screen-buffer word addresses, |
// |               unpacks the 7-bit char code and keeps syncs aligned (3 clk).|
// |               Define VGA_CURSOR_EN to add the blinking cursor overlay.    |
// | Revision    : 1.1 - blink parameter always declared                        |
// +----------------------------------------------------------------------------+
module vga_tile_fetch
    import vga_tile_fetch_pkg::*;
#(
    parameter int CHAR_W     = c_char_w,
    parameter int WORD_CHARS = c_word_chars,
    parameter int ADDR_WIDTH = c_addr_width,
    parameter int BLINK_LOG2 = 5
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic [9:0]                   hcount_i,
    input  logic [9:0]                   vcount_i,
    input  logic                         video_on_i,
    input  logic                         hsync_i,
    input  logic                         vsync_i,
`ifdef VGA_CURSOR_EN
    input  logic [6:0]                   cursor_x_i,
    input  logic [4:0]                   cursor_y_i,
    output logic                         cursor_o,
`endif
    output logic [ADDR_WIDTH-1:0]        buf_addr_o,
    input  logic [CHAR_W*WORD_CHARS-1:0] buf_data_i,
    output logic [CHAR_W-1:0]            char_o,
    output logic [3:0]                   glyph_row_o,
    output logic [2:0]                   glyph_col_o,
    output logic                         video_on_o,
    output logic                         hsync_o,
    output logic                         vsync_o
);

    localparam int c_slot_w = $clog2(WORD_CHARS);

    logic [5:0]            w_row;
    logic [6:0]            w_col;
    logic [ADDR_WIDTH-1:0] w_addr;
    logic [ADDR_WIDTH-1:0] r_buf_addr;
    logic [c_slot_w-1:0]   r_slot1;
    logic [c_slot_w-1:0]   r_slot2;
    logic [CHAR_W-1:0]     r_char;
    ctrl_t                 w_ctrl_in;
    ctrl_t                 w_ctrl_out;

    assign w_row = vcount_i[9:4];
    assign w_col = hcount_i[9:3];

    // row*20 as (row<<4)+(row<<2), plus the word index within the row.
    assign w_addr = ADDR_WIDTH'({w_row, 4'b0000}) + ADDR_WIDTH'({w_row, 2'b00})
                  + ADDR_WIDTH'(w_col[6:c_slot_w]);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_buf_addr <= '0;
            r_slot1    <= '0;
            r_slot2    <= '0;
            r_char     <= '0;
        end else begin
            // Holding the address in blanking keeps it inside the 600-word buffer.
            if (video_on_i) r_buf_addr <= w_addr;
            r_slot1 <= w_col[c_slot_w-1:0];
            r_slot2 <= r_slot1;
            r_char  <= buf_data_i[r_slot2*CHAR_W +: CHAR_W];
        end
    end

    assign buf_addr_o = r_buf_addr;

    assign w_ctrl_in = '{hsync: hsync_i, vsync: vsync_i, video_on: video_on_i,
                         glyph_row: vcount_i[3:0], glyph_col: hcount_i[2:0]};

    vga_delay_line #(
        .WIDTH     ($bits(ctrl_t)),
        .DEPTH     (3),
        .RESET_VAL (c_ctrl_reset)
    ) u_ctrl_dly (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .d_i   (w_ctrl_in),
        .q_o   (w_ctrl_out)
    );

    assign hsync_o     = w_ctrl_out.hsync;
    assign vsync_o     = w_ctrl_out.vsync;
    assign video_on_o  = w_ctrl_out.video_on;
    assign glyph_row_o = w_ctrl_out.glyph_row;
    assign glyph_col_o = w_ctrl_out.glyph_col;
    assign char_o      = w_ctrl_out.video_on ? r_char : '0;

`ifdef VGA_CURSOR_EN
    logic                r_vsync_q;
    logic [BLINK_LOG2:0] r_frame;
    logic                w_hit;
    logic                w_hit_d;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_vsync_q <= 1'b1;
            r_frame   <= '0;
        end else begin
            r_vsync_q <= vsync_i;
            if (r_vsync_q && !vsync_i) r_frame <= r_frame + 1'b1;
        end
    end

    // Range checks stop an out-of-range cursor aliasing onto blanking tiles.
    assign w_hit = r_frame[BLINK_LOG2]
                && (cursor_x_i < 7'(c_h_tiles)) && (cursor_y_i < 5'(c_v_tiles))
                && (w_col == cursor_x_i) && (w_row == {1'b0, cursor_y_i});

    vga_delay_line #(
        .WIDTH     (1),
        .DEPTH     (3),
        .RESET_VAL (1'b0)
    ) u_cursor_dly (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .d_i   (w_hit),
        .q_o   (w_hit_d)
    );

    assign cursor_o = w_hit_d && w_ctrl_out.video_on;
`endif

endmodule
`default_nettype wire
